// File: rtl/spwm_gate_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spwm_gate_ctrl_pkg
//
// Shared definitions for the sinusoidal PWM gate controller:
//   - control FSM state enumeration
//   - LUT sample width and address widths
//   - default carrier / sine table sizes, prescale and dead-time values
//   - small helper to decode the "modulating" states
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package spwm_gate_ctrl_pkg;

    // Width of every carrier and sine LUT sample.
    localparam int SAMPLE_W      = 12;

    // Address widths of the two external lookup tables.
    localparam int TCP_ADDR_W    = 9;
    localparam int SINE_ADDR_W   = 12;

    // Default table geometry and timing.
    localparam int DEF_TCP_SIZE  = 407;
    localparam int DEF_SINE_SIZE = 50;
    localparam int DEF_PRESCALE  = 1;
    localparam int DEF_DT_CYCLES = 8;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FAULT = 2'd3
    } ctrl_state_e;

    // RUN and DRAIN are the states in which the carrier advances and the
    // gates are modulated.
    function automatic logic is_active(input ctrl_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage : spwm_gate_ctrl_pkg

// File: rtl/spwm_deadtime.sv
// ---------------------------------------------------------------------------
// spwm_deadtime
//
// Converts a single demand bit into a complementary pair of gate drives with
// a guaranteed dead-time between them. Whenever the demand changes (or the
// first demand arrives after enable rises) both gates are forced low and held
// low for exactly DT_CYCLES cycles before the gate matching the latest demand
// is turned on. A further demand change during the dead-time restarts the
// count and retargets to the newest demand, so the abandoned side never
// glitches on.
//
// The demand input is sampled combinationally: the edge at which a change is
// first seen is the edge at which both gates drop. The registered copy of the
// demand ("target") is the side that will be driven once the dead-time ends.
//
// Ports:
//   clk_in   in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   demand   in   1 = high side requested, 0 = low side requested
//   enable   in   0 forces both gates low and clears all internal state
//   gate_hi  out  registered high-side drive
//   gate_lo  out  registered low-side drive
// ---------------------------------------------------------------------------
module spwm_deadtime
    import spwm_gate_ctrl_pkg::*;
#(
    parameter int DT_CYCLES = DEF_DT_CYCLES
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic demand,
    input  logic enable,
    output logic gate_hi,
    output logic gate_lo
);

    // Loaded on a demand change; the gate turns on at the edge after the
    // counter has reached zero, giving exactly DT_CYCLES low cycles.
    localparam logic [7:0] DT_LOAD = 8'(DT_CYCLES - 1);

    logic       target;   // registered demand being worked towards
    logic       locked;   // a valid demand has been captured since enable
    logic       pending;  // dead-time in progress
    logic [7:0] dt_cnt;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            target  <= 1'b0;
            locked  <= 1'b0;
            pending <= 1'b0;
            dt_cnt  <= 8'd0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else if (!enable) begin
            target  <= 1'b0;
            locked  <= 1'b0;
            pending <= 1'b0;
            dt_cnt  <= 8'd0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else if (!locked || (demand != target)) begin
            // New or changed demand: both gates off, (re)start dead-time.
            target  <= demand;
            locked  <= 1'b1;
            pending <= 1'b1;
            dt_cnt  <= DT_LOAD;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else if (pending) begin
            if (dt_cnt == 8'd0) begin
                pending <= 1'b0;
                gate_hi <= target;
                gate_lo <= ~target;
            end else begin
                dt_cnt  <= dt_cnt - 8'd1;
            end
        end
    end

endmodule : spwm_deadtime

// File: rtl/spwm_gate_ctrl.sv
// ---------------------------------------------------------------------------
// spwm_gate_ctrl
//
// Sinusoidal PWM gate controller for one half-bridge. A triangular carrier
// and a sine reference are read from two external synchronous LUTs. Their
// comparison gives the switching demand, which is passed through a dead-time
// stage to produce the complementary high/low gate drives.
//
// Control FSM: IDLE -> RUN on start, RUN -> DRAIN on stop, DRAIN -> IDLE at
// the end of the current carrier period, any state -> FAULT while fault is
// high, FAULT -> IDLE on start once fault has cleared.
//
// Ports:
//   clk_in       in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   pulse: begin modulation from IDLE / clear FAULT
//   stop         in   pulse: stop at the end of the carrier period
//   fault        in   level: immediate gate shutdown
//   tcp_addr     out  carrier LUT address, 0..TCP_SIZE-1
//   tcp_val      in   carrier LUT data, one cycle after tcp_addr
//   sine_addr    out  sine LUT address, 0..SINE_SIZE-1
//   sine_val     in   sine LUT data, one cycle after sine_addr
//   gate_hi      out  registered high-side drive
//   gate_lo      out  registered low-side drive
//   busy         out  high in RUN and DRAIN
//   period_done  out  one-cycle pulse when tcp_addr wraps to 0
// ---------------------------------------------------------------------------
module spwm_gate_ctrl
    import spwm_gate_ctrl_pkg::*;
#(
    parameter int TCP_SIZE  = DEF_TCP_SIZE,
    parameter int SINE_SIZE = DEF_SINE_SIZE,
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int DT_CYCLES = DEF_DT_CYCLES
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   fault,
    output logic [TCP_ADDR_W-1:0]  tcp_addr,
    input  logic [SAMPLE_W-1:0]    tcp_val,
    output logic [SINE_ADDR_W-1:0] sine_addr,
    input  logic [SAMPLE_W-1:0]    sine_val,
    output logic                   gate_hi,
    output logic                   gate_lo,
    output logic                   busy,
    output logic                   period_done
);

    localparam logic [TCP_ADDR_W-1:0]  TCP_LAST   = TCP_ADDR_W'(TCP_SIZE - 1);
    localparam logic [SINE_ADDR_W-1:0] SINE_LAST  = SINE_ADDR_W'(SINE_SIZE - 1);
    localparam logic [7:0]             PRESC_LAST = 8'(PRESCALE - 1);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic [7:0] presc_q;
    logic       tick;
    logic       wrap;
    logic       enter_run;
    logic       data_valid_q;
    logic       dt_enable;
    logic       demand;

    // ---------------------------------------------------------------------
    // Step timing. The carrier only advances while modulating and never on
    // the edge where a fault is being taken, so the addresses freeze at the
    // value they held when the fault arrived.
    // ---------------------------------------------------------------------
    assign tick      = is_active(state_q) && !fault && (presc_q == PRESC_LAST);
    assign wrap      = tick && (tcp_addr == TCP_LAST);
    assign enter_run = (state_q != ST_RUN) && (state_d == ST_RUN);

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment at the top of this block keeps every
    // path assigning state_d, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start) state_d = ST_RUN;
                ST_RUN:   if (stop)  state_d = ST_DRAIN;
                ST_DRAIN: if (wrap)  state_d = ST_IDLE;
                ST_FAULT: if (start) state_d = ST_IDLE;
                default:             state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = is_active(state_q);

    // ---------------------------------------------------------------------
    // Prescaler and LUT address generation
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= 8'd0;
            tcp_addr    <= '0;
            sine_addr   <= '0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (enter_run) begin
                presc_q   <= 8'd0;
                tcp_addr  <= '0;
                sine_addr <= '0;
            end else if (is_active(state_q) && !fault) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= 8'd0;
                end else begin
                    presc_q <= presc_q + 8'd1;
                end

                if (wrap) begin
                    tcp_addr    <= '0;
                    period_done <= 1'b1;
                    if (sine_addr == SINE_LAST) begin
                        sine_addr <= '0;
                    end else begin
                        sine_addr <= sine_addr + SINE_ADDR_W'(1);
                    end
                end else if (tick) begin
                    tcp_addr <= tcp_addr + TCP_ADDR_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Demand qualification
    //
    // The LUTs return data one cycle after the address, so the first sample
    // that belongs to this run is on the bus one cycle after entering RUN.
    // data_valid_q marks that point. The dead-time stage is enabled only
    // while the FSM is modulating now and will still be modulating after the
    // edge, so leaving RUN/DRAIN (stop completion, fault) drops both gates on
    // that same edge, and stale data from a previous run is never used on
    // the entry edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= is_active(state_q);
        end
    end

    assign dt_enable = is_active(state_q) && is_active(state_d) && data_valid_q;

    // Equal samples give no high-side demand.
    assign demand = (sine_val > tcp_val);

    // ---------------------------------------------------------------------
    // Dead-time insertion. The stage registers the demand, so address to
    // gate-change latency is two cycles.
    // ---------------------------------------------------------------------
    spwm_deadtime #(
        .DT_CYCLES (DT_CYCLES)
    ) u_deadtime (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .demand  (demand),
        .enable  (dt_enable),
        .gate_hi (gate_hi),
        .gate_lo (gate_lo)
    );

endmodule : spwm_gate_ctrl

// File: tb/tb_spwm_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spwm_gate_ctrl
//
// Self-checking bench for spwm_gate_ctrl. Behavioural synchronous LUTs feed
// the DUT. For every stimulus sequence the expected per-cycle outputs are
// derived from the carrier geometry and the 2-cycle / DT-cycle timing rules,
// pushed into a queue when the stimulus is started, and popped and compared
// one cycle at a time just after each rising edge.
// ---------------------------------------------------------------------------
module tb_spwm_gate_ctrl;
    import spwm_gate_ctrl_pkg::*;

    localparam int T    = 407;   // carrier samples per period
    localparam int SN   = 50;    // sine samples
    localparam int DT   = 8;     // dead-time cycles
    localparam int LAT  = 2;     // address-to-demand latency
    localparam int LVL  = 800;   // sine reference level
    // Triangle carrier, step 20: address 40 is the first at or above 800
    // on the rising slope (equal gives no demand), 367 the first below 800
    // on the falling slope.
    localparam int CD   = 40;
    localparam int CU   = 367;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        stop   = 1'b0;
    logic        fault  = 1'b0;
    logic [8:0]  tcp_addr;
    logic [11:0] tcp_val  = '0;
    logic [11:0] sine_addr;
    logic [11:0] sine_val = '0;
    logic        gate_hi;
    logic        gate_lo;
    logic        busy;
    logic        period_done;

    logic [11:0] tcp_lut  [0:511];
    logic [11:0] sine_lut [0:4095];

    typedef struct {
        logic [8:0]  tcp;
        logic [11:0] sine;
        logic        hi;
        logic        lo;
        logic        busy;
        logic        pd;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    spwm_gate_ctrl #(
        .TCP_SIZE  (T),
        .SINE_SIZE (SN),
        .PRESCALE  (1),
        .DT_CYCLES (DT)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .fault       (fault),
        .tcp_addr    (tcp_addr),
        .tcp_val     (tcp_val),
        .sine_addr   (sine_addr),
        .sine_val    (sine_val),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .busy        (busy),
        .period_done (period_done)
    );

    // External synchronous LUTs: data one cycle after address.
    always @(posedge clk_in) begin
        tcp_val  <= tcp_lut[tcp_addr];
        sine_val <= sine_lut[sine_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic bit in_rng(input int k, input int lo, input int hi);
        return (k >= lo) && (k < hi);
    endfunction

    task automatic push_exp(input int tcp, input int sine, input bit hi, input bit lo,
                            input bit bsy, input bit pd);
        exp_t e;
        e.tcp  = 9'(tcp);
        e.sine = 12'(sine);
        e.hi   = hi;
        e.lo   = lo;
        e.busy = bsy;
        e.pd   = pd;
        exp_q.push_back(e);
    endtask

    // Wait for the next edge, then compare all outputs against the oldest
    // queued expectation.
    task automatic step(input string ph, input int k);
        exp_t e;
        @(posedge clk_in);
        #1;
        if (exp_q.size() == 0) begin
            check($sformatf("%s_queue_empty@%0d", ph, k), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_tcp_addr@%0d", ph, k),  32'(tcp_addr),    32'(e.tcp));
            check($sformatf("%s_sine_addr@%0d", ph, k), 32'(sine_addr),   32'(e.sine));
            check($sformatf("%s_gate_hi@%0d", ph, k),   32'(gate_hi),     32'(e.hi));
            check($sformatf("%s_gate_lo@%0d", ph, k),   32'(gate_lo),     32'(e.lo));
            check($sformatf("%s_busy@%0d", ph, k),      32'(busy),        32'(e.busy));
            check($sformatf("%s_period_done@%0d", ph, k), 32'(period_done), 32'(e.pd));
            check($sformatf("%s_overlap@%0d", ph, k),   32'(gate_hi & gate_lo), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Triangle carrier 0..4060..20, sine flat at LVL.
        for (int i = 0; i < 512; i++) begin
            if (i <= 203)    tcp_lut[i] = 12'(i * 20);
            else if (i < T)  tcp_lut[i] = 12'((T - 1 - i) * 20);
            else             tcp_lut[i] = 12'd0;
        end
        for (int i = 0; i < 4096; i++) sine_lut[i] = 12'(LVL);

        // ---------------- reset state ----------------
        #1;
        check("rst_tcp_addr",    32'(tcp_addr),    32'd0);
        check("rst_sine_addr",   32'(sine_addr),   32'd0);
        check("rst_gate_hi",     32'(gate_hi),     32'd0);
        check("rst_gate_lo",     32'(gate_lo),     32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_period_done", 32'(period_done), 32'd0);
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step("idle", k);

        // ---------------- full run, start ignored, graceful stop ----------
        // Start edge is k=0; stop is raised at tcp_addr=100 of the second
        // period and completes at the wrap, k=2T.
        for (int k = 0; k <= 2 * T + 6; k++) begin
            bit act;
            bit hi;
            bit lo;
            act = (k < 2 * T);
            hi  = in_rng(k, LAT + DT, CD + LAT)
               || in_rng(k, CU + LAT + DT, T + CD + LAT)
               || in_rng(k, T + CU + LAT + DT, 2 * T);
            lo  = in_rng(k, CD + LAT + DT, CU + LAT)
               || in_rng(k, T + CD + LAT + DT, T + CU + LAT);
            push_exp(act ? (k % T) : 0, act ? (k / T) : 2, hi, lo, act,
                     (k == T) || (k == 2 * T));
        end
        start = 1'b1;
        for (int k = 0; k <= 2 * T + 6; k++) begin
            step("run", k);
            if (k == 0)         start = 1'b0;
            if (k == 200)       start = 1'b1;
            if (k == 201)       start = 1'b0;
            if (k == T + 100)   stop  = 1'b1;
            if (k == T + 101)   stop  = 1'b0;
        end

        // ---------------- 3-cycle demand notch, fault, restart ----------
        for (int i = 0; i < 512; i++) tcp_lut[i] = 12'd0;
        for (int i = 100; i < 103; i++) tcp_lut[i] = 12'd4000;
        for (int k = 0; k < 148; k++) begin
            if (k <= 120)
                push_exp(k, 0, in_rng(k, LAT + DT, 100 + LAT) || (k >= 103 + LAT + DT),
                         0, 1, 0);
            else if (k < 132)
                push_exp(120, 0, 0, 0, 0, 0);
            else
                push_exp(k - 132, 0, (k - 132) >= LAT + DT, 0, 1, 0);
        end
        start = 1'b1;
        for (int k = 0; k < 148; k++) begin
            step("notch", k);
            case (k)
                0:   start = 1'b0;
                120: begin fault = 1'b1; start = 1'b1; end
                121: start = 1'b0;
                123: start = 1'b1;
                124: start = 1'b0;
                126: fault = 1'b0;
                128: start = 1'b1;
                129: start = 1'b0;
                131: start = 1'b1;
                132: start = 1'b0;
                default: ;
            endcase
        end

        // ---------------- reset mid-RUN with gate_hi high ----------------
        #2 rst_n = 1'b0;
        #1;
        check("arst_gate_hi",     32'(gate_hi),     32'd0);
        check("arst_gate_lo",     32'(gate_lo),     32'd0);
        check("arst_busy",        32'(busy),        32'd0);
        check("arst_tcp_addr",    32'(tcp_addr),    32'd0);
        check("arst_sine_addr",   32'(sine_addr),   32'd0);
        check("arst_period_done", 32'(period_done), 32'd0);
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) push_exp(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step("post_rst", k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spwm_gate_ctrl

// File: doc/spwm_gate_ctrl.md
SPWM_GATE_CTRL -- requirements
Module: spwm_gate_ctrl

Interface
REQ-001 Parameter: TCP_SIZE, default 407, number of carrier LUT samples per carrier period.
REQ-002 Parameter: SINE_SIZE, default 50, number of sine LUT samples per fundamental period; one sample per carrier period.
REQ-003 Parameter: PRESCALE, default 1, clk_in cycles per carrier sample step; legal range 1..255.
REQ-004 Parameter: DT_CYCLES, default 8, dead-time in clk_in cycles; legal range 1..255.
REQ-005 Port: clk_in  in  1  single clock; all logic on its rising edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: start  in  1  one-cycle pulse; begins modulation from IDLE or clears FAULT.
REQ-008 Port: stop  in  1  one-cycle pulse; requests a graceful stop at the end of the carrier period.
REQ-009 Port: fault  in  1  level; immediate gate shutdown.
REQ-010 Port: tcp_addr  out  9  carrier LUT read address, 0..TCP_SIZE-1.
REQ-011 Port: tcp_val  in  12  carrier LUT data; valid one cycle after tcp_addr.
REQ-012 Port: sine_addr  out  12  sine LUT read address, 0..SINE_SIZE-1.
REQ-013 Port: sine_val  in  12  sine LUT data; valid one cycle after sine_addr.
REQ-014 Port: gate_hi / gate_lo  out  1 each  high-side and low-side switch drive, registered.
REQ-015 Port: busy  out  1  high in RUN and DRAIN.
REQ-016 Port: period_done  out  1  one-cycle pulse when tcp_addr wraps from TCP_SIZE-1 to 0.

Function
REQ-017 Control FSM states SHALL be IDLE, RUN, DRAIN and FAULT.
REQ-018 FSM transitions SHALL be:
  - IDLE->RUN on start;
  - RUN->DRAIN on stop;
  - DRAIN->IDLE on the cycle the wrap is committed;
  - any state->FAULT when fault=1;
  - FAULT->IDLE on start while fault=0.
REQ-019 fault SHALL take priority over start and stop in the same cycle; stop SHALL take priority over start; start in RUN or DRAIN SHALL be ignored.
REQ-020 Entering RUN SHALL clear tcp_addr, sine_addr, prescaler and the dead-time counter to 0.
REQ-021 In RUN and DRAIN, a step tick SHALL occur every PRESCALE cycles.
REQ-022 On each tick, tcp_addr SHALL increment; at TCP_SIZE-1 it SHALL wrap to 0 and pulse period_done.
REQ-023 On each carrier wrap, sine_addr SHALL increment, wrapping from SINE_SIZE-1 to 0.
REQ-024 Demand SHALL be (sine_val > tcp_val), an unsigned 12-bit compare registered one cycle after data valid; equal values SHALL give demand=0.
REQ-025 Demand SHALL be ignored until the first LUT data after entering RUN is valid.
REQ-026 Address-to-demand latency SHALL be 2 cycles.
REQ-027 When demand changes, both gates SHALL be driven 0 for exactly DT_CYCLES cycles before the gate for the new demand is asserted.
REQ-028 If demand toggles again during the dead-time, the counter SHALL restart and the latest demand SHALL be the target.
REQ-029 gate_hi and gate_lo SHALL never both be 1 in any cycle.
REQ-030 On the first valid demand after entering RUN, the corresponding gate SHALL assert after DT_CYCLES cycles with both gates low.
REQ-031 In IDLE and FAULT, both gates SHALL be 0 and the addresses SHALL hold their values.
REQ-032 On fault, both gates SHALL be 0 on the next clock edge.
REQ-033 In DRAIN, modulation SHALL continue unchanged until the wrap; at DRAIN->IDLE, both gates SHALL go to 0.

Reset
REQ-034 With rst_n=0, asynchronously: state=IDLE; tcp_addr=0; sine_addr=0; gate_hi=0; gate_lo=0; busy=0; period_done=0; all counters 0.
REQ-035 Reset asserted mid-operation SHALL abort immediately with no dead-time sequence; after release the block SHALL remain in IDLE until start.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, the 12-bit sample width constant and the default TCP_SIZE, SINE_SIZE and DT_CYCLES values.
REQ-037 Dead-time insertion SHALL be one sub-module, spwm_deadtime, with inputs demand and enable and outputs gate_hi and gate_lo.
REQ-038 The LUTs SHALL remain external to this block.

Verification
REQ-039 Start, PRESCALE=1, behavioural LUT models -> tcp_addr 0,1,..,406,0; period_done high for exactly 1 cycle every 407 cycles; sine_addr +1 per wrap.
REQ-040 sine_val=800, carrier crossing 800 -> gate_hi falls at the crossing+2 cycles; gate_lo rises exactly 8 cycles later; both never 1.
REQ-041 Demand pulse 3 cycles wide, DT_CYCLES=8 -> both gates low for 8 cycles after the second edge; no glitch to the abandoned side.
REQ-042 stop at tcp_addr=100 -> busy stays 1 until the wrap after 406, then IDLE with gates 0 and period_done pulsed once.
REQ-043 fault asserted in RUN together with start -> gates 0 next edge; FAULT held while fault=1; start with fault=0 -> IDLE, then a second start -> RUN from address 0.
REQ-044 rst_n low for 1 cycle mid-RUN with gate_hi=1 -> all outputs 0 immediately (before the next edge); no activity until start.
